// File: rtl/ioctl_tx_streamer.sv
// Streams a byte image from a synchronous source memory onto the ioctl download bus.
// Optional IOCTL_TX_CHECKSUM_EN adds a running mod-256 sum of written bytes on ioctl_sum.
module ioctl_tx_streamer #(
  parameter int unsigned ADDR_W      = 25,
  parameter int unsigned SRC_LATENCY = 1,
  parameter int unsigned WR_GAP      = 2,
  parameter int unsigned TAIL_CYCLES = 4
) (
  input  logic              clk_48,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        index_in,
  input  logic [ADDR_W-1:0] length,
  output logic              src_rd,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        src_data,
  output logic              ioctl_download,
  output logic              ioctl_wr,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_index,
  input  logic              ioctl_wait,
`ifdef IOCTL_TX_CHECKSUM_EN
  output logic [7:0]        ioctl_sum,
`endif
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StWrite, StGap, StTail} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [31:0]       tmr_q, tmr_d;
  logic              src_rd_q, src_rd_d, dl_q, dl_d, wr_q, wr_d, busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0] src_addr_q, src_addr_d, addr_q, addr_d;
  logic [7:0]        dout_q, dout_d, index_q, index_d;
  logic              accept_start;

  assign accept_start = (state_q == StIdle) && start && !abort;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    tmr_d      = tmr_q;
    src_rd_d   = 1'b0;
    src_addr_d = src_addr_q;
    dl_d       = dl_q;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    dout_d     = dout_q;
    index_d    = index_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept_start) begin
          if (length != '0) begin
            index_d    = index_in;
            len_d      = length;
            cnt_d      = '0;
            dl_d       = 1'b1;
            busy_d     = 1'b1;
            src_rd_d   = 1'b1;
            src_addr_d = '0;
            state_d    = StFetch;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StFetch: begin
        tmr_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (tmr_q == SRC_LATENCY - 1) begin
          dout_d  = src_data;
          addr_d  = cnt_q;
          state_d = StWrite;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      StWrite: begin
        if (!ioctl_wait) begin
          wr_d    = 1'b1;
          cnt_d   = cnt_q + ADDR_W'(1);
          tmr_d   = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (tmr_q == WR_GAP - 1) begin
          tmr_d = '0;
          if (cnt_q == len_q) begin
            state_d = StTail;
          end else begin
            src_rd_d   = 1'b1;
            src_addr_d = cnt_q;
            state_d    = StFetch;
          end
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      StTail: begin
        if (tmr_q == TAIL_CYCLES - 1) begin
          dl_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Abort overrides everything but leaves the last address/data/index visible.
    if (abort && (state_q != StIdle)) begin
      state_d  = StIdle;
      dl_d     = 1'b0;
      wr_d     = 1'b0;
      src_rd_d = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      addr_d   = addr_q;
      dout_d   = dout_q;
    end
  end

  always_ff @(posedge clk_48) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      len_q      <= '0;
      tmr_q      <= '0;
      src_rd_q   <= 1'b0;
      src_addr_q <= '0;
      dl_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      dout_q     <= '0;
      index_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      tmr_q      <= tmr_d;
      src_rd_q   <= src_rd_d;
      src_addr_q <= src_addr_d;
      dl_q       <= dl_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      index_q    <= index_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef IOCTL_TX_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (accept_start) begin
      sum_d = '0;
    end else if (wr_q) begin
      sum_d = sum_q + dout_q;
    end
  end

  always_ff @(posedge clk_48) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign ioctl_sum = sum_q;
`endif

  assign src_rd         = src_rd_q;
  assign src_addr       = src_addr_q;
  assign ioctl_download = dl_q;
  assign ioctl_wr       = wr_q;
  assign ioctl_addr     = addr_q;
  assign ioctl_dout     = dout_q;
  assign ioctl_index    = index_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_ioctl_tx_streamer.sv
// Randomized bench for ioctl_tx_streamer against a per-byte timing/data reference model.
module tb_ioctl_tx_streamer;
  localparam int unsigned AW = 25;
  localparam int L = 1;
  localparam int G = 2;
  localparam int T = 4;
  localparam int Budget = 3000;

  logic          clk_48 = 1'b0;
  logic          reset, start, abort, ioctl_wait;
  logic [7:0]    index_in, src_data;
  logic [AW-1:0] length, src_addr, ioctl_addr;
  logic          src_rd, ioctl_download, ioctl_wr, busy, done;
  logic [7:0]    ioctl_dout, ioctl_index;
`ifdef IOCTL_TX_CHECKSUM_EN
  logic [7:0]    ioctl_sum;
`endif

  always #5 clk_48 = ~clk_48;

  ioctl_tx_streamer dut (
    .clk_48        (clk_48),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .index_in      (index_in),
    .length        (length),
    .src_rd        (src_rd),
    .src_addr      (src_addr),
    .src_data      (src_data),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_index   (ioctl_index),
    .ioctl_wait    (ioctl_wait),
`ifdef IOCTL_TX_CHECKSUM_EN
    .ioctl_sum     (ioctl_sum),
`endif
    .busy          (busy),
    .done          (done)
  );

  // Source image store with one cycle of read latency.
  logic [7:0] mem [256];
  always @(posedge clk_48) if (src_rd) src_data <= mem[src_addr[7:0]];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  bit pat [4096];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one transfer; abort_after>0 aborts right after that many writes are seen.
  task automatic run_xfer(input logic [AW-1:0] len, input logic [7:0] idx, input int stall_pct,
                          input int stall_at, input int stall_len, input int abort_after);
    int exp_w[$];
    int got_w[$];
    logic [AW-1:0] got_a[$];
    logic [7:0] got_d[$];
    int n_model, e, t, exp_done, done_rel, abort_rel, last_dl, n_rd, n_done;
    logic [7:0] exp_sum;
    foreach (pat[i]) pat[i] = ($urandom_range(99) < stall_pct);
    for (int i = 0; i < stall_len; i++) pat[stall_at + i] = 1'b1;
    for (int i = 4000; i < 4096; i++) pat[i] = 1'b0;
    // Reference: byte k's WRITE slot opens at e; the write strobe follows the first
    // cycle in that slot with wait low; the next slot opens one byte period later.
    n_model = (abort_after > 0) ? abort_after : int'(len);
    e = 2 + L;
    for (int k = 0; k < n_model; k++) begin
      t = e;
      while (pat[t]) t++;
      exp_w.push_back(t + 1);
      e = t + 1 + G + 1 + L;
    end
    exp_done = (n_model > 0) ? exp_w[n_model-1] + G + T : 1;
    done_rel = -1; abort_rel = -1; last_dl = -1; n_rd = 0; n_done = 0;

    @(negedge clk_48);
    start = 1'b1; length = len; index_in = idx; abort = 1'b0; ioctl_wait = pat[0];
    for (int rel = 1; rel < Budget; rel++) begin
      @(negedge clk_48);
      start = 1'b0; abort = 1'b0; index_in = 8'($urandom);
      if (ioctl_wr) begin
        got_w.push_back(rel); got_a.push_back(ioctl_addr); got_d.push_back(ioctl_dout);
      end
      if (src_rd) n_rd++;
      if (done) begin done_rel = rel; n_done++; end
      if (ioctl_download) last_dl = rel;
`ifdef IOCTL_TX_CHECKSUM_EN
      if (rel == 1) check_eq("sum_cleared", 64'(ioctl_sum), 64'h0);
`endif
      if (abort_rel >= 0 && rel == abort_rel + 1) begin
        check_eq("abort_download", 64'(ioctl_download), 64'h0);
        check_eq("abort_busy", 64'(busy), 64'h0);
      end
      if (rel == 7 && busy) begin
        start = 1'b1; length = AW'(5); index_in = ~idx;
      end
      if (abort_after > 0 && got_w.size() == abort_after && abort_rel < 0) begin
        abort = 1'b1; abort_rel = rel;
      end
      ioctl_wait = pat[rel];
      if (done_rel >= 0 && rel >= done_rel + 4) break;
      if (abort_rel >= 0 && rel >= abort_rel + 6) break;
    end
    ioctl_wait = 1'b0;
    if (done_rel < 0 && abort_rel < 0) check_eq("timeout", 64'h1, 64'h0);

    check_eq("wr_count", 64'(got_w.size()), 64'(n_model));
    exp_sum = 8'h00;
    for (int k = 0; k < n_model && k < got_w.size(); k++) begin
      check_eq($sformatf("wr%0d_cycle", k), 64'(got_w[k]), 64'(exp_w[k]));
      check_eq($sformatf("wr%0d_addr", k), 64'(got_a[k]), 64'(k));
      check_eq($sformatf("wr%0d_dout", k), 64'(got_d[k]), 64'(mem[k[7:0]]));
      exp_sum = exp_sum + mem[k[7:0]];
    end
    check_eq("src_rd_count", 64'(n_rd), 64'(n_model));
    check_eq("busy_end", 64'(busy), 64'h0);
    if (abort_after > 0) begin
      check_eq("abort_no_done", 64'(n_done), 64'h0);
      check_eq("abort_index", 64'(ioctl_index), 64'(idx));
    end else begin
      check_eq("done_count", 64'(n_done), 64'h1);
      check_eq("done_cycle", 64'(done_rel), 64'(exp_done));
      check_eq("download_last", 64'(last_dl), (len == '0) ? 64'hffff_ffff_ffff_ffff
                                                          : 64'(exp_done - 1));
      if (len != '0) check_eq("index_kept", 64'(ioctl_index), 64'(idx));
`ifdef IOCTL_TX_CHECKSUM_EN
      check_eq("sum_at_done", 64'(ioctl_sum), 64'(exp_sum));
`endif
    end
  endtask

  initial begin
    int any_hi;
    reset = 1'b1; start = 1'b0; abort = 1'b0; ioctl_wait = 1'b0;
    index_in = 8'h00; length = '0;
    foreach (mem[i]) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk_48);
    check_eq("rst_download", 64'(ioctl_download), 64'h0);
    check_eq("rst_wr", 64'(ioctl_wr), 64'h0);
    check_eq("rst_addr", 64'(ioctl_addr), 64'h0);
    check_eq("rst_dout", 64'(ioctl_dout), 64'h0);
    check_eq("rst_index", 64'(ioctl_index), 64'h0);
    check_eq("rst_src", 64'({src_rd, src_addr}), 64'h0);
    check_eq("rst_busy_done", 64'({busy, done}), 64'h0);
    reset = 1'b0;

    mem[0] = 8'hA5; mem[1] = 8'h5A; mem[2] = 8'hFF;
    run_xfer(AW'(3), 8'h3C, 0, 0, 0, 0);
    run_xfer(AW'(3), 8'h3D, 0, 8, 10, 0);
    run_xfer(AW'(0), 8'h11, 0, 0, 0, 0);
    foreach (mem[i]) mem[i] = 8'($urandom);
    run_xfer(AW'(100), 8'h77, 20, 0, 0, 4);
    for (int r = 0; r < 6; r++) begin
      foreach (mem[i]) mem[i] = 8'($urandom);
      run_xfer(AW'($urandom_range(40, 1)), 8'($urandom), int'($urandom_range(40)), 0, 0, 0);
    end
    run_xfer({AW{1'b1}}, 8'hE1, 10, 0, 0, 2);

    // start together with abort while idle must not begin a transfer.
    @(negedge clk_48);
    start = 1'b1; abort = 1'b1; length = AW'(5); index_in = 8'h42;
    any_hi = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_48);
      start = 1'b0; abort = 1'b0;
      if (ioctl_download || busy || done || src_rd) any_hi++;
    end
    check_eq("start_abort_idle", 64'(any_hi), 64'h0);

    // Synchronous reset in the middle of a transfer.
    @(negedge clk_48);
    start = 1'b1; length = AW'(10); index_in = 8'h99;
    repeat (12) begin
      @(negedge clk_48);
      start = 1'b0;
    end
    check_eq("mid_busy", 64'(busy), 64'h1);
    reset = 1'b1;
    @(negedge clk_48);
    reset = 1'b0;
    check_eq("mid_rst_outs", 64'({ioctl_download, ioctl_wr, busy, done, src_rd}), 64'h0);
    check_eq("mid_rst_index", 64'(ioctl_index), 64'h0);
    any_hi = 0;
    repeat (8) begin
      @(negedge clk_48);
      if (done || ioctl_download) any_hi++;
    end
    check_eq("mid_rst_quiet", 64'(any_hi), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
